kernel_job_driver: RTL and testbench
====================================

KERNEL_JOB_DRIVER -- requirements
Module: kernel_job_driver

Interface
REQ-001 SHALL have parameter IN_W, default 10, kernel operand width.
REQ-002 SHALL have parameter OUT_W, default 10, kernel result width.
REQ-003 SHALL have parameter JOBS_W, default 8, job-count width.
REQ-004 SHALL have parameter DEPTH, default 4, result FIFO depth and maximum in-flight jobs (power of two, >=2).
REQ-005 SHALL have parameter CYC_W, default 32, cycle-counter width.
REQ-006 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port go  input  1  level start request, sampled in IDLE only.
REQ-009 SHALL have port n  input  IN_W  base operand, latched at start.
REQ-010 SHALL have port jobs  input  JOBS_W  invocation count, latched at start.
REQ-011 SHALL have ports k_n output IN_W, k_n_vld output 1, k_n_rdy input 1: operand channel to the kernel.
REQ-012 SHALL have ports k_res input OUT_W, k_res_vld input 1, k_res_rdy output 1: result channel from the kernel.
REQ-013 SHALL have ports result output OUT_W, result_valid output 1, result_ready input 1: host result stream.
REQ-014 SHALL have outputs busy 1, done 1, err 1, cycles CYC_W: status.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE; busy=1 exactly in RUN, done=1 exactly in DONE.
REQ-016 IDLE with go=1 SHALL latch n, jobs; clear issued, received, outstanding, cycles, err; next state RUN, or DONE if jobs==0.
REQ-017 go SHALL be ignored in RUN and DONE.
REQ-018 In RUN, k_n SHALL equal latched n + issued, modulo 2^IN_W.
REQ-019 k_n_vld SHALL be 1 iff state==RUN, issued<jobs, and outstanding+fifo_count<DEPTH, all from current registered values (no same-cycle credit from pops).
REQ-020 A transfer k_n_vld&k_n_rdy SHALL increment issued and outstanding; k_n SHALL stay stable while k_n_vld=1 and k_n_rdy=0.
REQ-021 k_res_rdy SHALL be 1 iff state==RUN.
REQ-022 k_res_vld&k_res_rdy with outstanding>0 SHALL push k_res into the FIFO, decrement outstanding, increment received.
REQ-023 k_res_vld&k_res_rdy with outstanding==0 SHALL drop the data and set err (sticky until next start or reset).
REQ-024 Simultaneous issue and accepted result SHALL leave outstanding unchanged.
REQ-025 FIFO SHALL be first-word-fall-through: result_valid = not empty, result = head entry; pop on result_valid&result_ready.
REQ-026 Simultaneous push and pop SHALL leave fifo_count unchanged, in any state; credit rule guarantees no push when full.
REQ-027 cycles SHALL increment each cycle in RUN, saturating at 2^CYC_W-1, and hold in IDLE/DONE until next start.
REQ-028 RUN SHALL go to DONE on the cycle the jobs-th result is accepted; that cycle counts in cycles.
REQ-029 DONE SHALL go to IDLE when go==0 and FIFO empty; FIFO continues draining in DONE.
REQ-030 First k_n_vld SHALL assert one cycle after go is accepted; result appears on result one cycle after k_res acceptance.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE and clear FIFO, counters, err, latched values, including mid-RUN; in-flight kernel results are forgotten.
REQ-032 During and after reset: k_n_vld=0, k_res_rdy=0, result_valid=0, busy=0, done=0, err=0, cycles=0, k_n=0, result=0.

Verification
REQ-033 n=5, jobs=3, kernel echoes operand+1 with 1-cycle latency, result_ready=1 -> results 6,7,8 in order, done=1, err=0.
REQ-034 jobs=8, DEPTH=4, result_ready=0, kernel always ready -> exactly 4 issues, k_n_vld=0 thereafter; raising result_ready resumes issue, all 8 results delivered.
REQ-035 n=1022, IN_W=10, jobs=4 -> k_n sequence 1022,1023,0,1.
REQ-036 jobs=0 -> DONE the cycle after go, cycles=0, no k_n_vld; go low -> IDLE.
REQ-037 k_res_vld pulse with no job issued -> err=1, FIFO empty; rst mid-RUN with 2 jobs in flight -> all outputs at reset values next cycle.
REQ-038 jobs=1, kernel latency 1 -> cycles=2 at DONE; held until next go.

Source files
------------

// File: rtl/kernel_job_driver.sv
// kernel_job_driver: issues a run of consecutive operands (n, n+1, ...) to a
// streaming kernel and buffers its results in a small FWFT FIFO for the host.
// Issue is credit-limited so that in-flight jobs plus buffered results never
// exceed DEPTH. This means a kernel result always has a free FIFO slot.
//
// Handshake rule used on every channel (k_n, k_res, result): a transfer happens
// on a rising clk edge where valid and ready are both 1. The sender holds its
// data stable while valid=1 and ready=0. Valid never depends on ready in the
// same cycle.
module kernel_job_driver #(
  parameter int IN_W   = 10,
  parameter int OUT_W  = 10,
  parameter int JOBS_W = 8,
  parameter int DEPTH  = 4,
  parameter int CYC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [IN_W-1:0]   n,
  input  logic [JOBS_W-1:0] jobs,
  output logic [IN_W-1:0]   k_n,
  output logic              k_n_vld,
  input  logic              k_n_rdy,
  input  logic [OUT_W-1:0]  k_res,
  input  logic              k_res_vld,
  output logic              k_res_rdy,
  output logic [OUT_W-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CYC_W-1:0]  cycles,
  output logic [1:0]        state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [IN_W-1:0]   n_q;
  logic [JOBS_W-1:0] jobs_q, issued_q, received_q;
  logic [CW-1:0]     outstanding_q, fifo_count_q;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [OUT_W-1:0]  mem_q [DEPTH];
  logic [CYC_W-1:0]  cycles_q;
  logic              err_q;

  logic start, issue_fire, res_fire, push, drop, pop, last_res, fifo_empty;

  assign fifo_empty = (fifo_count_q == '0);
  assign start      = (state_q == S_IDLE) && go;
  assign issue_fire = k_n_vld && k_n_rdy;
  assign res_fire   = k_res_vld && k_res_rdy;
  assign push       = res_fire && (outstanding_q != '0);
  assign drop       = res_fire && (outstanding_q == '0);
  assign pop        = !fifo_empty && result_ready;
  assign last_res   = push && (({1'b0, received_q} + 1'b1) == {1'b0, jobs_q});

  // Next-state and handshake outputs; issue credit uses registered counts only.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    k_res_rdy = 1'b0;
    k_n_vld   = 1'b0;
    k_n       = '0;
    unique case (state_q)
      S_IDLE: if (go) state_d = (jobs == '0) ? S_DONE : S_RUN;
      S_RUN: begin
        busy      = 1'b1;
        k_res_rdy = 1'b1;
        k_n       = n_q + IN_W'(issued_q);
        k_n_vld   = (issued_q < jobs_q) &&
                    (({1'b0, outstanding_q} + {1'b0, fifo_count_q}) < DEPTH_V);
        if (last_res) state_d = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (!go && fifo_empty) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Job bookkeeping: latched operands, issue/receive counters, error, cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q           <= '0;
      jobs_q        <= '0;
      issued_q      <= '0;
      received_q    <= '0;
      outstanding_q <= '0;
      cycles_q      <= '0;
      err_q         <= 1'b0;
    end else if (start) begin
      n_q           <= n;
      jobs_q        <= jobs;
      issued_q      <= '0;
      received_q    <= '0;
      outstanding_q <= '0;
      cycles_q      <= '0;
      err_q         <= 1'b0;
    end else begin
      if (issue_fire) issued_q <= issued_q + 1'b1;
      if (push) received_q <= received_q + 1'b1;
      if (issue_fire && !push)      outstanding_q <= outstanding_q + 1'b1;
      else if (!issue_fire && push) outstanding_q <= outstanding_q - 1'b1;
      if (drop) err_q <= 1'b1;
      if (state_q == S_RUN && cycles_q != '1) cycles_q <= cycles_q + 1'b1;
    end
  end

  // Result FIFO pointers and occupancy; push and pop together leave the count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      fifo_count_q <= fifo_count_q + 1'b1;
      else if (!push && pop) fifo_count_q <= fifo_count_q - 1'b1;
    end
  end

  // FIFO storage; contents are only visible through the non-empty gate below.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= k_res;
  end

  assign result_valid = !fifo_empty;
  assign result       = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign err          = err_q;
  assign cycles       = cycles_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_kernel_job_driver.sv
// Bench for kernel_job_driver: a kernel stub with programmable latency and
// random readiness, a host with random result_ready, and a job-level reference
// model tracking issued/received counts, buffered results and status.
module tb_kernel_job_driver;

  localparam int IN_W   = 10;
  localparam int OUT_W  = 10;
  localparam int JOBS_W = 8;
  localparam int DEPTH  = 4;
  localparam int CYC_W  = 32;

  logic              clk = 1'b0;
  logic              rst, go, k_n_rdy, k_res_vld, result_ready;
  logic [IN_W-1:0]   n, k_n;
  logic [JOBS_W-1:0] jobs;
  logic [OUT_W-1:0]  k_res, result;
  logic              k_n_vld, k_res_rdy, result_valid, busy, done, err;
  logic [CYC_W-1:0]  cycles;
  logic [1:0]        state_dbg;

  kernel_job_driver #(.IN_W(IN_W), .OUT_W(OUT_W), .JOBS_W(JOBS_W), .DEPTH(DEPTH), .CYC_W(CYC_W)) dut (
    .clk(clk), .rst(rst), .go(go), .n(n), .jobs(jobs),
    .k_n(k_n), .k_n_vld(k_n_vld), .k_n_rdy(k_n_rdy),
    .k_res(k_res), .k_res_vld(k_res_vld), .k_res_rdy(k_res_rdy),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .busy(busy), .done(done), .err(err), .cycles(cycles), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  // reference model
  int  m_n, m_jobs, m_issued, m_recv, m_fifo, m_cycles;
  bit  m_run, m_done, m_err;
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] kq_v[$];
  int               kq_t[$];
  logic [IN_W-1:0]  issue_log[$];
  logic [OUT_W-1:0] pop_log[$];
  int cyc = 0;
  int dut_issues;
  int kready_pct = 100, rready_pct = 100, lat = 1;
  bit inject = 0;

  task automatic model_clear();
    m_run = 0; m_done = 0; m_err = 0; m_fifo = 0; m_cycles = 0;
    m_issued = 0; m_recv = 0; m_n = 0; m_jobs = 0;
    exp_q.delete(); kq_v.delete(); kq_t.delete();
  endtask

  // One clock cycle: drive at negedge, check just after, then advance.
  task automatic tick();
    int out0, fifo0;
    bit run0, done0, exp_vld;
    logic [IN_W-1:0]  exp_kn;
    logic [OUT_W-1:0] exp_r;
    k_n_rdy      = ($urandom_range(99) < kready_pct);
    result_ready = ($urandom_range(99) < rready_pct);
    if (inject) begin
      k_res_vld = 1'b1; k_res = OUT_W'($urandom);
    end else if (kq_t.size() != 0 && kq_t[0] <= cyc) begin
      k_res_vld = 1'b1; k_res = kq_v[0];
    end else begin
      k_res_vld = 1'b0; k_res = '0;
    end
    #1;
    run0 = m_run; done0 = m_done; fifo0 = m_fifo;
    out0 = m_issued - m_recv;
    exp_vld = m_run && (m_issued < m_jobs) && (out0 + m_fifo < DEPTH);
    exp_kn  = IN_W'(m_n + m_issued);

    checks++;
    if (k_n_vld !== exp_vld) begin
      errors++; $display("FAIL k_n_vld: got %0b want %0b (cyc %0d)", k_n_vld, exp_vld, cyc);
    end
    if (exp_vld) begin
      checks++;
      if (k_n !== exp_kn) begin
        errors++; $display("FAIL k_n: got %0d want %0d", k_n, exp_kn);
      end
    end
    checks++;
    if ({busy, done, k_res_rdy} !== {run0, done0, run0}) begin
      errors++; $display("FAIL status: got busy/done/k_res_rdy %b want %b", {busy, done, k_res_rdy}, {run0, done0, run0});
    end
    checks++;
    if (result_valid !== (fifo0 > 0)) begin
      errors++; $display("FAIL result_valid: got %0b want %0b", result_valid, (fifo0 > 0));
    end
    if (fifo0 > 0 && exp_q.size() > 0) begin
      checks++;
      if (result !== exp_q[0]) begin
        errors++; $display("FAIL result: got %0d want %0d", result, exp_q[0]);
      end
    end
    checks++;
    if (err !== m_err) begin
      errors++; $display("FAIL err: got %0b want %0b", err, m_err);
    end
    checks++;
    if (cycles !== CYC_W'(m_cycles)) begin
      errors++; $display("FAIL cycles: got %0d want %0d", cycles, m_cycles);
    end

    if (k_n_vld && k_n_rdy) dut_issues++;
    if (go && !run0 && !done0) begin
      m_n = int'(n); m_jobs = int'(jobs);
      m_issued = 0; m_recv = 0; m_cycles = 0; m_err = 0;
      m_run = (jobs != 0); m_done = (jobs == 0);
    end else begin
      if (exp_vld && k_n_rdy) begin
        issue_log.push_back(k_n);
        kq_v.push_back(OUT_W'(int'(exp_kn) + 1));
        kq_t.push_back(cyc + lat);
        m_issued++;
      end
      if (fifo0 > 0 && result_ready) begin
        pop_log.push_back(result);
        if (exp_q.size() > 0) exp_r = exp_q.pop_front();
        m_fifo--;
      end
      if (k_res_vld && run0) begin
        if (!inject) begin
          void'(kq_v.pop_front());
          void'(kq_t.pop_front());
        end
        if (out0 > 0) begin
          exp_q.push_back(k_res);
          m_recv++; m_fifo++;
          if (m_recv == m_jobs) begin m_run = 0; m_done = 1; end
        end else begin
          m_err = 1;
        end
      end
      if (run0) m_cycles++;
      if (done0 && !go && fifo0 == 0) m_done = 0;
    end
    inject = 0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic start_job(input int nv, input int jv);
    n = IN_W'(nv); jobs = JOBS_W'(jv); go = 1'b1;
    issue_log.delete(); pop_log.delete(); dut_issues = 0;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int b = 0;
    while ((m_run || m_done) && b < budget) begin tick(); b++; end
    checks++;
    if (m_run || m_done) begin
      errors++; $display("FAIL wait_idle: timeout after %0d cycles, want idle", budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; go = 1'b0; k_n_rdy = 1'b0; k_res_vld = 1'b0; k_res = '0; result_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({k_n_vld, k_res_rdy, result_valid, busy, done, err} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 000000", {k_n_vld, k_res_rdy, result_valid, busy, done, err});
    end
    checks++;
    if (cycles !== '0) begin errors++; $display("FAIL reset_cycles: got %0d want 0", cycles); end
    checks++;
    if (k_n !== '0) begin errors++; $display("FAIL reset_k_n: got %0d want 0", k_n); end
    checks++;
    if (result !== '0) begin errors++; $display("FAIL reset_result: got %0d want 0", result); end
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_basic();
    logic [OUT_W-1:0] want[3] = '{10'd6, 10'd7, 10'd8};
    int b = 0;
    kready_pct = 100; rready_pct = 100; lat = 1;
    start_job(5, 3);
    while (m_run && b < 100) begin tick(); b++; end
    checks++;
    if (done !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL basic_done: got done %0b err %0b want 1 0", done, err);
    end
    wait_idle(100);
    checks++;
    if (pop_log.size() != 3) begin
      errors++; $display("FAIL basic_count: got %0d want 3", pop_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (pop_log[i] !== want[i]) begin
          errors++; $display("FAIL basic_result%0d: got %0d want %0d", i, pop_log[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    kready_pct = 100; rready_pct = 0; lat = 1;
    start_job(100, 8);
    repeat (20) tick();
    checks++;
    if (dut_issues != 4) begin
      errors++; $display("FAIL bp_issues: got %0d want 4", dut_issues);
    end
    checks++;
    if (k_n_vld !== 1'b0) begin
      errors++; $display("FAIL bp_stall: got k_n_vld %0b want 0", k_n_vld);
    end
    rready_pct = 100;
    wait_idle(200);
    checks++;
    if (pop_log.size() != 8) begin
      errors++; $display("FAIL bp_delivered: got %0d want 8", pop_log.size());
    end
  endtask

  task automatic test_wrap();
    logic [IN_W-1:0] want[4] = '{10'd1022, 10'd1023, 10'd0, 10'd1};
    kready_pct = 100; rready_pct = 100; lat = 2;
    start_job(1022, 4);
    wait_idle(200);
    checks++;
    if (issue_log.size() != 4) begin
      errors++; $display("FAIL wrap_count: got %0d want 4", issue_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (issue_log[i] !== want[i]) begin
          errors++; $display("FAIL wrap_k_n%0d: got %0d want %0d", i, issue_log[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_zero_jobs();
    kready_pct = 100; rready_pct = 100; lat = 1;
    n = 10'd7; jobs = '0; go = 1'b1;
    dut_issues = 0;
    tick();
    checks++;
    if (done !== 1'b1 || cycles !== '0 || k_n_vld !== 1'b0) begin
      errors++; $display("FAIL zero_done: got done %0b cycles %0d vld %0b want 1 0 0", done, cycles, k_n_vld);
    end
    tick(); tick();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL zero_hold: got done %0b want 1", done); end
    go = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || dut_issues != 0) begin
      errors++; $display("FAIL zero_idle: got done %0b busy %0b issues %0d want 0 0 0", done, busy, dut_issues);
    end
  endtask

  task automatic test_err_and_reset();
    kready_pct = 0; rready_pct = 100; lat = 4;
    start_job(3, 2);
    inject = 1;
    tick();
    checks++;
    if (err !== 1'b1 || result_valid !== 1'b0) begin
      errors++; $display("FAIL err_set: got err %0b valid %0b want 1 0", err, result_valid);
    end
    kready_pct = 100;
    repeat (3) tick();
    checks++;
    if (dut_issues != 2) begin
      errors++; $display("FAIL err_inflight: got %0d want 2", dut_issues);
    end
    test_reset();
  endtask

  task automatic test_cycles();
    int b = 0;
    kready_pct = 100; rready_pct = 100; lat = 1;
    start_job(20, 1);
    while (m_run && b < 50) begin tick(); b++; end
    checks++;
    if (done !== 1'b1 || cycles !== 32'd2) begin
      errors++; $display("FAIL cycles_done: got done %0b cycles %0d want 1 2", done, cycles);
    end
    wait_idle(50);
    repeat (3) tick();
    checks++;
    if (cycles !== 32'd2) begin errors++; $display("FAIL cycles_hold: got %0d want 2", cycles); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      kready_pct = $urandom_range(100, 30);
      rready_pct = $urandom_range(100, 20);
      lat        = $urandom_range(4, 1);
      start_job($urandom_range(1023, 0), $urandom_range(12, 1));
      wait_idle(3000);
      checks++;
      if (pop_log.size() != m_jobs) begin
        errors++; $display("FAIL rand_count%0d: got %0d want %0d", i, pop_log.size(), m_jobs);
      end
    end
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; n = '0; jobs = '0;
    k_n_rdy = 1'b0; k_res_vld = 1'b0; k_res = '0; result_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_jobs();
    test_err_and_reset();
    test_cycles();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
